happy_step_sequencer: RTL and testbench
=======================================

// Module: happy_step_sequencer
// PURPOSE
//   Timed step generator that drives the 3-bit step input of the downstream HAPPY 7-seg decoder.
//   Replaces the manual SW[17:15] selection with an automatic left-to-right reveal.
//   Step sequence: Y, PY, PPY, APPY, HAPPY, hold, blank, then stop or loop.
//   Supports pause and loop modes, and emits busy/done status for the board top level.
// PARAMETERS
//   TICK_DIV    25_000_000  CLOCK_50 cycles per display tick (0.5 s); legal range >= 2
//   HOLD_TICKS  1           extra ticks the full word (step 101) is held; legal range >= 0
// PORTS
//   CLOCK_50  in   1  the only clock; all logic on rising edge
//   rst       in   1  synchronous, active-high reset
//   start     in   1  level input; its rising edge launches a sequence
//   pause     in   1  level; while 1, the tick counter and step are frozen
//   loop_en   in   1  sampled at end of BLANK; 1 = restart at step 001
//   step      out  3  registered step code to the decoder
//   busy      out  1  1 from the first step-001 cycle until IDLE re-entry
//   done      out  1  one-cycle pulse on IDLE re-entry after a non-looping sequence
// BEHAVIOUR
//   Reset values: step=000, busy=0, done=0, state=IDLE, tick_cnt=0, hold_cnt=0, start_q=0.
//   Start detection:
//     - start_q registers start every cycle; start_rise = start & ~start_q.
//     - start_rise is honoured only in IDLE; ignored while busy.
//     - rst in the same cycle as start_rise: rst wins.
//   Tick generation:
//     - tick_cnt counts 0..TICK_DIV-1 in RUN, HOLD and BLANK when pause=0.
//     - tick=1 when tick_cnt==TICK_DIV-1 and pause=0; tick_cnt then wraps to 0.
//     - tick_cnt is cleared on IDLE->RUN.
//   FSM (all outputs registered):
//     - IDLE:  step=000. On start_rise (cycle N) -> RUN with step=001 and busy=1 at N+1.
//     - RUN:   on tick, step+1. On the tick at step=100 -> HOLD with step=101, hold_cnt=0.
//     - HOLD:  step=101. On tick: if hold_cnt==HOLD_TICKS -> BLANK with step=110; else hold_cnt+1.
//              Net effect: 101 is shown for (1+HOLD_TICKS)*TICK_DIV cycles.
//     - BLANK: step=110 for one tick. On tick:
//              loop_en=1 -> RUN with step=001; busy stays 1; done stays 0.
//              loop_en=0 -> IDLE with step=000, busy=0 and done=1, all on the same edge.
//     - done is high for exactly one cycle.
//   Pause vs tick:
//     - pause=1 suppresses tick, so pause wins over a coincident tick.
//     - Pause of P cycles delays every later transition by exactly P.
//     - pause has no effect in IDLE.
//     - start_rise with pause=1 still enters RUN at step=001, which then stays frozen.
//   rst at any point, including mid-HOLD or mid-pause:
//     - next cycle returns every register to its reset value.
//     - no done pulse is produced.
//   Step codes 111 and 000 are never produced outside IDLE.
//   tick_cnt width = $clog2(TICK_DIV); step arithmetic is 3-bit; wrap cannot occur.
// STRUCTURE
//   Shared include happy_defs.vh:
//     - STEP_OFF=000, STEP_Y=001, STEP_PY=010, STEP_PPY=011, STEP_APPY=100,
//       STEP_HAPPY=101, STEP_BLANK=110
//     - state encodings S_IDLE, S_RUN, S_HOLD, S_BLANK
//   Sub-module tick_divider (params DIV; ports CLOCK_50, rst, en, clr, tick) holds the tick counter.
//   FSM, start edge detect and hold_cnt stay in this module.
// TESTING  (TICK_DIV=4, HOLD_TICKS=1; cycle numbers are the edge at which the output is seen)
//   1. rst cycles 0-2; start 0->1 sampled at 10.
//      -> step=001 at 11, 010 at 15, 011 at 19, 100 at 23, 101 at 27, 110 at 35.
//      -> step=000 with done=1 at 39; done=0 and busy=0 from 40.
//   2. As test 1, plus pause=1 for cycles 16-23.
//      -> step holds 010 through 23; 011 at 27; every later edge +8; done at 47.
//   3. loop_en=1 throughout -> step=001 at 39, busy stays 1, no done.
//      loop_en dropped at 50 -> done=1 at 67, step=000.
//   4. start held high from 10 to 100 -> exactly one sequence and one done pulse (39).
//      A second edge at 20 (start low at 19) is ignored.
//   5. rst at 30 (HOLD) -> step=000, busy=0, done=0 at 31.
//      New start_rise at 40 -> step=001 at 41 with timing as test 1, offset +30.
//   6. rst and start_rise in the same cycle -> remains IDLE, step=000.

Source files
------------

// File: rtl/happy_step_sequencer_pkg.sv
// Shared step codes and FSM state encoding for the HAPPY reveal sequencer.
package happy_step_sequencer_pkg;

   localparam logic [2:0] STEP_OFF   = 3'b000;
   localparam logic [2:0] STEP_Y     = 3'b001;
   localparam logic [2:0] STEP_PY    = 3'b010;
   localparam logic [2:0] STEP_PPY   = 3'b011;
   localparam logic [2:0] STEP_APPY  = 3'b100;
   localparam logic [2:0] STEP_HAPPY = 3'b101;
   localparam logic [2:0] STEP_BLANK = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD,
      S_BLANK
   } state_t;

endpackage

// File: rtl/happy_step_sequencer_tick_divider.sv
// Display tick generator: one-cycle tick every DIV enabled cycles.
module tick_divider #(
   parameter int DIV = 25_000_000
) (
   input  logic CLOCK_50,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] tickCnt;

   assign tick = en && (tickCnt == LAST);

   // Clear takes priority so a new sequence always starts on a full tick period.
   always_ff @(posedge CLOCK_50) begin
      if (rst || clr) begin
         tickCnt <= '0;
      end else if (en) begin
         if (tick) begin
            tickCnt <= '0;
         end else begin
            tickCnt <= tickCnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/happy_step_sequencer.sv
// Automatic left-to-right reveal of "HAPPY": drives the decoder step code with pause/loop.
module happy_step_sequencer
   import happy_step_sequencer_pkg::*;
#(
   parameter int TICK_DIV   = 25_000_000,
   parameter int HOLD_TICKS = 1
) (
   input  logic       CLOCK_50,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       loop_en,
   output logic [2:0] step,
   output logic       busy,
   output logic       done
);

   localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS);

   state_t        state;
   logic          startQ;
   logic          startRise;
   logic [HW-1:0] holdCnt;
   logic          tick;
   logic          tickEn;
   logic          tickClr;

   assign startRise = start & ~startQ;
   assign tickEn    = (state != S_IDLE) && !pause;
   assign tickClr   = (state == S_IDLE) && startRise;

   tick_divider #(
      .DIV(TICK_DIV)
   ) u_tick (
      .CLOCK_50(CLOCK_50),
      .rst     (rst),
      .en      (tickEn),
      .clr     (tickClr),
      .tick    (tick)
   );

   // Sequence FSM; done defaults low so it can only ever be a single-cycle pulse.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state   <= S_IDLE;
         step    <= STEP_OFF;
         busy    <= 1'b0;
         done    <= 1'b0;
         holdCnt <= '0;
         startQ  <= 1'b0;
      end else begin
         startQ <= start;
         done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (startRise) begin
                  state <= S_RUN;
                  step  <= STEP_Y;
                  busy  <= 1'b1;
               end
            end
            S_RUN: begin
               if (tick) begin
                  if (step == STEP_APPY) begin
                     state   <= S_HOLD;
                     step    <= STEP_HAPPY;
                     holdCnt <= '0;
                  end else begin
                     step <= 3'(step + 3'd1);
                  end
               end
            end
            S_HOLD: begin
               if (tick) begin
                  if (holdCnt == HOLD_LAST) begin
                     state <= S_BLANK;
                     step  <= STEP_BLANK;
                  end else begin
                     holdCnt <= holdCnt + 1'b1;
                  end
               end
            end
            S_BLANK: begin
               if (tick) begin
                  if (loop_en) begin
                     state <= S_RUN;
                     step  <= STEP_Y;
                  end else begin
                     state <= S_IDLE;
                     step  <= STEP_OFF;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               step  <= STEP_OFF;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_happy_step_sequencer.sv
// Scoreboard bench for happy_step_sequencer with TICK_DIV=4, HOLD_TICKS=1.
module tb_happy_step_sequencer;

   typedef struct {
      int         cyc;
      logic [2:0] step;
      logic       busy;
      logic       done;
   } evt_t;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       loopEn = 1'b0;
   logic [2:0] step;
   logic       busy;
   logic       done;

   int   cyc = 0;
   int   base = 0;
   int   testsRun = 0;
   int   testsFailed = 0;
   bit   monEn = 1'b0;
   logic [4:0] prevOut = '0;
   evt_t expQ[$];

   happy_step_sequencer #(
      .TICK_DIV  (4),
      .HOLD_TICKS(1)
   ) dut (
      .CLOCK_50(clock),
      .rst     (rst),
      .start   (start),
      .pause   (pause),
      .loop_en (loopEn),
      .step    (step),
      .busy    (busy),
      .done    (done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: every output change must match the next expected event, including its edge number.
   always @(negedge clock) begin
      if (monEn && ({step, busy, done} !== prevOut)) begin
         evt_t e;
         int   rel;
         rel = cyc - base;
         testsRun++;
         if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpected change at edge %0d: got step=%b busy=%b done=%b, required no change",
                     rel, step, busy, done);
         end else begin
            e = expQ.pop_front();
            if (e.cyc != rel || e.step !== step || e.busy !== busy || e.done !== done) begin
               testsFailed++;
               $display("[TB] FAIL event: got edge %0d step=%b busy=%b done=%b, required edge %0d step=%b busy=%b done=%b",
                        rel, step, busy, done, e.cyc, e.step, e.busy, e.done);
            end
         end
      end
      prevOut = {step, busy, done};
   end

   task automatic pushExp(input int c, input logic [2:0] s, input logic b, input logic d);
      evt_t e;
      e.cyc  = c;
      e.step = s;
      e.busy = b;
      e.done = d;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic p, input logic l);
      rst    = r;
      start  = s;
      pause  = p;
      loopEn = l;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      testsRun++;
      if (actual !== required) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
      end
   endtask

   task automatic goTo(input int k);
      while (cyc - base < k) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Edge 0 of a test is the edge just passed; reset is held for cycles 0-2.
   task automatic beginTest(input logic l);
      @(posedge clock);
      #1;
      base = cyc;
      applyStimulus(1'b1, 1'b0, 1'b0, l);
      goTo(3);
      rst = 1'b0;
   endtask

   task automatic endTest(input string name, input int k);
      goTo(k);
      checkOutput(name, expQ.size(), 0);
      expQ.delete();
   endtask

   task automatic pushPlainRun(input int off);
      pushExp(11 + off, 3'b001, 1'b1, 1'b0);
      pushExp(15 + off, 3'b010, 1'b1, 1'b0);
      pushExp(19 + off, 3'b011, 1'b1, 1'b0);
      pushExp(23 + off, 3'b100, 1'b1, 1'b0);
      pushExp(27 + off, 3'b101, 1'b1, 1'b0);
      pushExp(35 + off, 3'b110, 1'b1, 1'b0);
      pushExp(39 + off, 3'b000, 1'b0, 1'b1);
      pushExp(40 + off, 3'b000, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset step", step, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      prevOut = {step, busy, done};
      monEn   = 1'b1;

      // Plain sequence
      beginTest(1'b0);
      pushPlainRun(0);
      goTo(10); start = 1'b1;
      goTo(12); start = 1'b0;
      endTest("plain queue drained", 50);

      // Pause for cycles 16-23 shifts everything after it by 8
      beginTest(1'b0);
      pushExp(11, 3'b001, 1'b1, 1'b0);
      pushExp(15, 3'b010, 1'b1, 1'b0);
      pushExp(27, 3'b011, 1'b1, 1'b0);
      pushExp(31, 3'b100, 1'b1, 1'b0);
      pushExp(35, 3'b101, 1'b1, 1'b0);
      pushExp(43, 3'b110, 1'b1, 1'b0);
      pushExp(47, 3'b000, 1'b0, 1'b1);
      pushExp(48, 3'b000, 1'b0, 1'b0);
      goTo(10); start = 1'b1;
      goTo(12); start = 1'b0;
      goTo(16); pause = 1'b1;
      goTo(24); pause = 1'b0;
      endTest("pause queue drained", 60);

      // Loop once, then loop_en dropped mid second pass
      beginTest(1'b1);
      pushExp(11, 3'b001, 1'b1, 1'b0);
      pushExp(15, 3'b010, 1'b1, 1'b0);
      pushExp(19, 3'b011, 1'b1, 1'b0);
      pushExp(23, 3'b100, 1'b1, 1'b0);
      pushExp(27, 3'b101, 1'b1, 1'b0);
      pushExp(35, 3'b110, 1'b1, 1'b0);
      pushExp(39, 3'b001, 1'b1, 1'b0);
      pushExp(43, 3'b010, 1'b1, 1'b0);
      pushExp(47, 3'b011, 1'b1, 1'b0);
      pushExp(51, 3'b100, 1'b1, 1'b0);
      pushExp(55, 3'b101, 1'b1, 1'b0);
      pushExp(63, 3'b110, 1'b1, 1'b0);
      pushExp(67, 3'b000, 1'b0, 1'b1);
      pushExp(68, 3'b000, 1'b0, 1'b0);
      goTo(10); start = 1'b1;
      goTo(12); start = 1'b0;
      goTo(50); loopEn = 1'b0;
      endTest("loop queue drained", 80);

      // Start held high with a second edge while busy: one sequence only
      beginTest(1'b0);
      pushPlainRun(0);
      goTo(10);  start = 1'b1;
      goTo(19);  start = 1'b0;
      goTo(20);  start = 1'b1;
      goTo(100); start = 1'b0;
      endTest("held start queue drained", 105);

      // Reset during HOLD, then a fresh sequence offset by 30
      beginTest(1'b0);
      pushExp(11, 3'b001, 1'b1, 1'b0);
      pushExp(15, 3'b010, 1'b1, 1'b0);
      pushExp(19, 3'b011, 1'b1, 1'b0);
      pushExp(23, 3'b100, 1'b1, 1'b0);
      pushExp(27, 3'b101, 1'b1, 1'b0);
      pushExp(31, 3'b000, 1'b0, 1'b0);
      pushPlainRun(30);
      goTo(10); start = 1'b1;
      goTo(12); start = 1'b0;
      goTo(30); rst = 1'b1;
      goTo(31); rst = 1'b0;
      goTo(40); start = 1'b1;
      goTo(42); start = 1'b0;
      endTest("mid-hold reset queue drained", 80);

      // Reset coincident with the start edge wins
      beginTest(1'b0);
      goTo(10); applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      goTo(11); applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      goTo(30);
      checkOutput("rst+start step", step, 0);
      checkOutput("rst+start busy", busy, 0);
      endTest("rst+start queue drained", 31);

      // Start while paused: step 001 frozen until pause releases
      beginTest(1'b0);
      pushExp(11, 3'b001, 1'b1, 1'b0);
      pushExp(24, 3'b010, 1'b1, 1'b0);
      pushExp(28, 3'b011, 1'b1, 1'b0);
      pushExp(31, 3'b000, 1'b0, 1'b0);
      goTo(10); applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      goTo(11); start = 1'b0;
      goTo(20); pause = 1'b0;
      goTo(30); rst = 1'b1;
      goTo(31); rst = 1'b0;
      endTest("paused start queue drained", 40);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
